// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one FA/FS cell plus a carry/borrow flop, LSB first, WIDTH clocks per operation.
// Optional feature macro: OVERFLOW_DETECT_EN (signed overflow flag; ovf tied low when undefined).
module serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);
    // Handshake: start is taken on a rising edge only while state is IDLE or DONE;
    // done is a one-cycle pulse, and result/cout/ovf are valid from that cycle on.

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] r_sh_q, r_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             a_i, b_i, x_i, s_i, c_nxt;
    logic [WIDTH-1:0] r_final;

    always_comb begin
        a_i     = a_sh_q[0];
        b_i     = b_sh_q[0];
        x_i     = a_i ^ b_i;
        s_i     = x_i ^ c_q;
        c_nxt   = mode_q ? ((~a_i & b_i) | (c_q & ~x_i))
                         : ((a_i & b_i) | (c_q & x_i));
        r_final = {s_i, r_sh_q[WIDTH-1:1]};
    end

`ifdef OVERFLOW_DETECT_EN
    // Operand sign bits are kept apart because the operand shift regs are consumed.
    logic [1:0] msb_q, msb_d;
    logic       ovf_q, ovf_d;
    logic       ovf_nxt;

    always_comb begin
        if (mode_q) ovf_nxt = (msb_q[1] != msb_q[0]) && (s_i != msb_q[1]);
        else        ovf_nxt = (msb_q[1] == msb_q[0]) && (s_i != msb_q[1]);
    end
`endif

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        r_sh_d   = r_sh_q;
        cnt_d    = cnt_q;
        c_d      = c_q;
        mode_d   = mode_q;
        result_d = result_q;
        cout_d   = cout_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef OVERFLOW_DETECT_EN
        msb_d    = msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    mode_d  = mode;
                    r_sh_d  = '0;
                    cnt_d   = '0;
                    c_d     = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_RUN;
`ifdef OVERFLOW_DETECT_EN
                    msb_d   = {a[WIDTH-1], b[WIDTH-1]};
`endif
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                r_sh_d = r_final;
                c_d    = c_nxt;
                if (cnt_q == LAST) begin
                    // Outputs are only ever loaded here, so no partial sum leaks out.
                    result_d = r_final;
                    cout_d   = c_nxt;
                    cnt_d    = '0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
`ifdef OVERFLOW_DETECT_EN
                    ovf_d    = ovf_nxt;
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            r_sh_q   <= '0;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            mode_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            r_sh_q   <= r_sh_d;
            cnt_q    <= cnt_d;
            c_q      <= c_d;
            mode_q   <= mode_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef OVERFLOW_DETECT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            msb_q <= 2'b00;
            ovf_q <= 1'b0;
        end else begin
            msb_q <= msb_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: three instances (WIDTH 8, 2, 32) checked against an arithmetic model.
module tb_serial_addsub;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        start8 = 0, mode8 = 0, busy8, done8, cout8, ovf8;
    logic [7:0]  a8 = 0, b8 = 0, res8;
    logic        start2 = 0, mode2 = 0, busy2, done2, cout2, ovf2;
    logic [1:0]  a2 = 0, b2 = 0, res2;
    logic        start32 = 0, mode32 = 0, busy32, done32, cout32, ovf32;
    logic [31:0] a32 = 0, b32 = 0, res32;

    serial_addsub #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .cout(cout8), .ovf(ovf8));
    serial_addsub #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(res2), .cout(cout2), .ovf(ovf2));
    serial_addsub #(.WIDTH(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .mode(mode32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(res32), .cout(cout32), .ovf(ovf32));

    int checks = 0;
    int errors = 0;
    logic [31:0] last_r[3];
    logic        last_c[3];
    logic        last_o[3];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int width_of(input int i);
        return (i == 0) ? 8 : (i == 1) ? 2 : 32;
    endfunction

    // Reference: plain integer arithmetic on unsigned and sign-extended operands.
    task automatic model(input int w, input logic md, input logic [31:0] av, input logic [31:0] bv,
                         output logic [31:0] r, output logic c, output logic o);
        longint mask, ua, ub, sa, sb, full, hi, lo;
        mask = (longint'(1) << w) - 1;
        ua   = longint'(av) & mask;
        ub   = longint'(bv) & mask;
        sa   = (ua >= (longint'(1) << (w - 1))) ? ua - (longint'(1) << w) : ua;
        sb   = (ub >= (longint'(1) << (w - 1))) ? ub - (longint'(1) << w) : ub;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        if (!md) begin
            full = ua + ub;
            r    = 32'(full & mask);
            c    = (full > mask);
            full = sa + sb;
        end else begin
            full = ua - ub;
            r    = 32'(full & mask);
            c    = (ua < ub);
            full = sa - sb;
        end
`ifdef OVERFLOW_DETECT_EN
        o = (full > hi) || (full < lo);
`else
        o = 1'b0;
        if (hi < lo) o = 1'b1;
`endif
    endtask

    task automatic set_in(input int i, input logic st, input logic md, input logic [31:0] av,
                          input logic [31:0] bv);
        case (i)
            0: begin start8 = st;  mode8 = md;  a8 = av[7:0];  b8 = bv[7:0];  end
            1: begin start2 = st;  mode2 = md;  a2 = av[1:0];  b2 = bv[1:0];  end
            default: begin start32 = st; mode32 = md; a32 = av; b32 = bv; end
        endcase
    endtask

    task automatic get_out(input int i, output logic bz, output logic dn, output logic [31:0] r,
                           output logic c, output logic o);
        case (i)
            0: begin bz = busy8;  dn = done8;  r = {24'd0, res8}; c = cout8;  o = ovf8;  end
            1: begin bz = busy2;  dn = done2;  r = {30'd0, res2}; c = cout2;  o = ovf2;  end
            default: begin bz = busy32; dn = done32; r = res32; c = cout32; o = ovf32; end
        endcase
    endtask

    // Called right after the accepting edge (+#1); returns at the negedge where done is seen.
    task automatic wait_and_check(input int i, input logic md, input logic [31:0] av,
                                  input logic [31:0] bv, input bit poke);
        int w, cyc;
        bit seen;
        logic bz, dn, c, o, ec, eo;
        logic [31:0] r, er;
        w = width_of(i);
        model(w, md, av, bv, er, ec, eo);
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < w + 6) begin
            @(negedge clk);
            cyc++;
            get_out(i, bz, dn, r, c, o);
            if (cyc == 1) check("busy_after_start", bz, 1);
            if (poke && cyc == 3) set_in(i, 1, ~md, $urandom, $urandom);
            if (poke && cyc == 4) set_in(i, 0, md, $urandom, $urandom);
            if (dn) seen = 1;
            else begin
                check("result_held", r, last_r[i]);
                check("cout_held", c, last_c[i]);
                check("ovf_held", o, last_o[i]);
            end
        end
        check("done_seen", seen, 1);
        check("latency", cyc, w + 1);
        check("busy_at_done", bz, 0);
        check("result", r, er);
        check("cout", c, ec);
        check("ovf", o, eo);
        last_r[i] = er;
        last_c[i] = ec;
        last_o[i] = eo;
    endtask

    task automatic do_op(input int i, input logic md, input logic [31:0] av, input logic [31:0] bv,
                         input bit poke);
        @(negedge clk);
        set_in(i, 1, md, av, bv);
        @(posedge clk);
        #1 set_in(i, 0, ~md, $urandom, $urandom);
        wait_and_check(i, md, av, bv, poke);
    endtask

    task automatic check_reset_state(input int i);
        logic bz, dn, c, o;
        logic [31:0] r;
        get_out(i, bz, dn, r, c, o);
        check("rst_busy", bz, 0);
        check("rst_done", dn, 0);
        check("rst_result", r, 0);
        check("rst_cout", c, 0);
        check("rst_ovf", o, 0);
        last_r[i] = '0;
        last_c[i] = 1'b0;
        last_o[i] = 1'b0;
    endtask

    logic [31:0] corners[3];

    initial begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) check_reset_state(i);
        rst = 1'b0;

        // Directed vectors at WIDTH 8
        do_op(0, 0, 32'h35, 32'h4A, 0);
        @(negedge clk);
        check("done_one_cycle", done8, 0);
        check("busy_idle", busy8, 0);
        do_op(0, 0, 32'hFF, 32'h01, 0);
        do_op(0, 1, 32'h10, 32'h20, 0);
        do_op(0, 0, 32'h7F, 32'h01, 0);
        do_op(0, 1, 32'h80, 32'h01, 0);

        // Abort mid-run with async reset after E4
        @(negedge clk);
        set_in(0, 1, 0, 32'hAA, 32'h77);
        @(posedge clk);
        #1 set_in(0, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) check_reset_state(i);
        @(negedge clk);
        rst = 1'b0;
        do_op(0, 0, 32'h01, 32'h02, 0);

        // Start during RUN is ignored; start held in DONE is accepted back-to-back
        do_op(0, 0, 32'h35, 32'h4A, 1);
        set_in(0, 1, 1, 32'h05, 32'h03);
        @(posedge clk);
        #1 set_in(0, 0, 0, $urandom, $urandom);
        wait_and_check(0, 1, 32'h05, 32'h03, 0);

        // Random WIDTH 8
        for (int k = 0; k < 40; k++)
            do_op(0, 1'($urandom_range(0, 1)), $urandom, $urandom, 0);

        // Exhaustive WIDTH 2
        for (int md = 0; md < 2; md++)
            for (int x = 0; x < 4; x++)
                for (int y = 0; y < 4; y++)
                    do_op(1, 1'(md), 32'(x), 32'(y), 0);

        // Corner vectors WIDTH 32
        corners[0] = 32'h0;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        for (int md = 0; md < 2; md++)
            for (int x = 0; x < 3; x++)
                for (int y = 0; y < 3; y++)
                    do_op(2, 1'(md), corners[x], corners[y], 0);
        for (int k = 0; k < 6; k++)
            do_op(2, 1'($urandom_range(0, 1)), $urandom, $urandom, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
